// File: rtl/mux_result_serializer.sv
// Result serializer: buffers selector words in a FIFO
// and shifts them out MSB-first as strobed serial frames.
module mux_result_serializer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     ser_out,
  output logic                     ser_frame,
  output logic                     ser_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(DATA_W);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic              frame_q, frame_d;
  logic              last_q, last_d;
  logic [7:0]        fcnt_q, fcnt_d;

  logic push;
  logic pop;
  logic last_bit;

  // Handshake, pop decision and FIFO pointer/count update
  always_comb begin
    in_ready = (count_q < CW'(DEPTH));
    push     = in_valid && in_ready;
    last_bit = (state_q == S_SHIFT) &&
               (bit_idx_q == '0);
    pop      = (count_q != '0) &&
               ((state_q == S_IDLE) || last_bit);
    wr_ptr_d = push ? wr_ptr_q + AW'(1)
                    : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1)
                   : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  // Frame sequencing: load, shift, chain or go idle
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    last_d    = last_q;
    fcnt_d    = fcnt_q;
    if (last_bit)
      fcnt_d = fcnt_q + 8'd1;
    if (pop) begin
      state_d   = S_SHIFT;
      shreg_d   = mem_q[rd_ptr_q];
      bit_idx_d = IW'(DATA_W - 1);
      frame_d   = 1'b1;
      last_d    = 1'b0;
    end else if (last_bit) begin
      state_d   = S_IDLE;
      shreg_d   = '0;
      bit_idx_d = '0;
      frame_d   = 1'b0;
      last_d    = 1'b0;
    end else if (state_q == S_SHIFT) begin
      shreg_d   = shreg_q << 1;
      bit_idx_d = bit_idx_q - IW'(1);
      last_d    = (bit_idx_q == IW'(1));
    end
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= in_data;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      frame_q   <= 1'b0;
      last_q    <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      last_q    <= last_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign ser_out    = shreg_q[DATA_W-1];
  assign ser_frame  = frame_q;
  assign ser_last   = last_q;
  assign fifo_count = count_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_mux_result_serializer.sv
// Bench for mux_result_serializer: queue-based
// reference model compared on every cycle.
module tb_mux_result_serializer;

  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ser_out;
  logic          ser_frame;
  logic          ser_last;
  logic [2:0]    fifo_count;
  logic [7:0]    frame_cnt;

  mux_result_serializer #(
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_frame (ser_frame),
    .ser_last  (ser_last),
    .fifo_count(fifo_count),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference: buffered words, word on the wire,
  // bits still to show, completed frames
  int       mq[$];
  logic [7:0] cur;
  int       rem;
  int       frames;

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return mq.size() < DEPTH;
  endfunction

  // one clock: drive, advance model, compare all outputs
  task automatic step(input bit v,
                      input logic [7:0] d,
                      input bit r);
    int  sz;
    bit  pu;
    rst = r;
    in_valid = v;
    in_data = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      rem = 0;
      frames = 0;
      cur = '0;
    end else begin
      sz = mq.size();
      pu = v && (sz < DEPTH);
      if (rem > 0) begin
        rem--;
        if (rem == 0)
          frames = (frames + 1) % 256;
      end
      if (rem == 0 && sz > 0) begin
        cur = 8'(mq.pop_front());
        rem = DW;
      end
      if (pu)
        mq.push_back(int'(d));
    end
    #1;
    check("ser_frame", int'(ser_frame), int'(rem > 0));
    check("ser_out", int'(ser_out),
          (rem > 0) ? int'(cur[rem-1]) : 0);
    check("ser_last", int'(ser_last), int'(rem == 1));
    check("fifo_count", int'(fifo_count), mq.size());
    check("frame_cnt", int'(frame_cnt), frames);
    check("in_ready", int'(in_ready), int'(m_ready()));
  endtask

  // present a word with valid held until accepted
  task automatic send(input logic [7:0] w);
    bit acc;
    int tries = 0;
    do begin
      acc = m_ready();
      step(1'b1, w, 1'b0);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: word %0h not accepted", w);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, $urandom_range(0, 255), 1'b0);
  endtask

  logic [7:0] w;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    cur = '0;
    rem = 0;
    frames = 0;

    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    idle(1);

    send(8'hA5);
    idle(10);

    send(8'h0F);
    send(8'hF0);
    send(8'h81);
    idle(28);

    for (int i = 0; i < 6; i++)
      send(8'(8'h10 + i));
    idle(56);

    send(8'hC3);
    idle(3);
    step(1'b0, 8'h00, 1'b1);
    idle(4);

    for (int i = 0; i < 256; i++)
      send(8'(i));
    idle(45);

    for (int i = 0; i < 400; i++) begin
      w = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0)
        step(1'b0, w, 1'b1);
      else
        step(1'($urandom_range(0, 1)), w, 1'b0);
    end
    idle(45);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
